mem_lsu: RTL and testbench

Load/store unit that drives the word-addressed data RAM as its sole initiator. Accepts one load or store request at a time from the execute stage and converts byte/halfword/word accesses into RAM word reads and writes. Sub-word stores use read-modify-write, loads are sign- or zero-extended, and misaligned or out-of-range accesses return an error without touching memory. Sits between the execute stage and the data RAM.

---
 rtl/mem_lsu.sv | 199 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit and the only initiator on the word-addressed
// data RAM. It takes one request at a time from the execute stage.
// Sub-word stores are done as read-modify-write. Loads are sign- or
// zero-extended. A misaligned or out-of-range access returns an error
// and never touches the RAM.
//
// Ports
//   clk_i, rst_ni       clock; asynchronous active-low reset
//   req_valid_i/ready_o request handshake (ready only in IDLE)
//   req_we_i            1 = store, 0 = load
//   req_size_i          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i      zero-extend the load result
//   req_addr_i          byte address
//   req_wdata_i         store data, right-aligned
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         extended load data (0 for stores and errors)
//   rsp_err_o           error flag, qualified by rsp_valid_o
//   ram_we_o            RAM write enable (RAM writes on the rising edge)
//   ram_addr_o          word-aligned byte address
//   ram_wdata_o         word to write
//   ram_rdata_i         combinational RAM read data for ram_addr_o
//
// state | meaning
// IDLE  | ready for a request
// RD    | RAM address driven, word captured at the end of the cycle
// WR    | write word driven, ram_we_o high
// RSP   | response pulse
module mem_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RSP} state_t;

  state_t state, state_nxt;

  logic                  op_we_q;
  logic [1:0]            op_size_q;
  logic                  op_uns_q;
  logic [1:0]            op_lane_q;
  logic [DATA_WIDTH-1:0] op_wdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  accept;
  logic                  req_err;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = req_valid_i && (state == ST_IDLE);

  // Any address bit at or above the RAM byte span puts it out of range.
  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = |req_addr_i[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|(req_addr_i >> (RAM_ADDR_WIDTH + 2)))
      req_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)
            state_nxt = ST_RSP;
          else if (req_we_i && (req_size_i == 2'b10))
            state_nxt = ST_WR;
          else
            state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = op_we_q ? ST_WR : ST_RSP;
      ST_WR:   state_nxt = ST_RSP;
      ST_RSP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = ram_rdata_i[7:0];
    case (op_lane_q)
      2'd1:    byte_sel = ram_rdata_i[15:8];
      2'd2:    byte_sel = ram_rdata_i[23:16];
      2'd3:    byte_sel = ram_rdata_i[31:24];
      default: byte_sel = ram_rdata_i[7:0];
    endcase
    half_sel = op_lane_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];

    load_ext = ram_rdata_i;
    case (op_size_q)
      2'b00:   load_ext = {{24{~op_uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~op_uns_q & half_sel[15]}}, half_sel};
      default: load_ext = ram_rdata_i;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes store data.
  always_comb begin
    merged = ram_rdata_i;
    if (op_size_q == 2'b00) begin
      case (op_lane_q)
        2'd1:    merged[15:8]  = op_wdata_q[7:0];
        2'd2:    merged[23:16] = op_wdata_q[7:0];
        2'd3:    merged[31:24] = op_wdata_q[7:0];
        default: merged[7:0]   = op_wdata_q[7:0];
      endcase
    end else if (op_lane_q[1]) begin
      merged[31:16] = op_wdata_q[15:0];
    end else begin
      merged[15:0] = op_wdata_q[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      op_we_q     <= 1'b0;
      op_size_q   <= 2'b00;
      op_uns_q    <= 1'b0;
      op_lane_q   <= 2'b00;
      op_wdata_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_we_q     <= req_we_i;
            op_size_q   <= req_size_i;
            op_uns_q    <= req_unsigned_i;
            op_lane_q   <= req_addr_i[1:0];
            op_wdata_q  <= req_wdata_i;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= '0;
            // Errors leave the RAM address/data untouched.
            if (!req_err) begin
              ram_addr_q <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              if (req_we_i && (req_size_i == 2'b10))
                ram_wdata_q <= req_wdata_i;
            end
          end
        end
        ST_RD: begin
          if (op_we_q)
            ram_wdata_q <= merged;
          else
            rsp_rdata_q <= load_ext;
        end
        ST_RSP: begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so that reset drops the
  // write enable asynchronously.
  assign req_ready_o = (state == ST_IDLE);
  assign ram_we_o    = (state == ST_WR);
  assign rsp_valid_o = (state == ST_RSP);
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural word RAM attached.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat;
  int          r_pulses;
  logic [31:0] r_wdata;
  logic        r_moved;

  mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(10)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_size_i    (req_size),
    .req_unsigned_i(req_uns),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .ram_we_o      (ram_we),
    .ram_addr_o    (ram_addr),
    .ram_wdata_o   (ram_wdata),
    .ram_rdata_i   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[11:2]] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, then watches the unit until its response.
  // r_lat counts edges from the accept edge through the edge that ends
  // the response cycle.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] addr_before;
    int k;
    logic got;
    @(negedge clk);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    addr_before = ram_addr;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_size = 2'($urandom); req_uns = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    r_pulses = 0; r_moved = 1'b0; r_wdata = 32'h0; r_rdata = 32'h0; r_err = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      if (ram_we) begin
        r_pulses++;
        r_wdata = ram_wdata;
      end
      if (ram_addr !== addr_before) r_moved = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        r_rdata = rsp_rdata;
        r_err = rsp_err;
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    r_lat = k + 1;
  endtask

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
  } err_vec_t;

  ld_vec_t  ld_tab[6];
  err_vec_t err_tab[4];

  initial begin
    int ready_low;
    int rsp_cnt;
    logic [31:0] b_rdata;
    logic a_err;
    logic b_seen;
    int k;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_uns = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_err", {31'd0, r_err}, 32'd0);
    check("sw_lat", r_lat, 32'd3);
    check("sw_pulses", r_pulses, 32'd1);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_rdata", r_rdata, 32'h0);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata", r_rdata, 32'hDEADBEEF);
    check("lw_err", {31'd0, r_err}, 32'd0);
    check("lw_lat", r_lat, 32'd3);
    check("lw_pulses", r_pulses, 32'd0);

    // byte store RMW; upper wdata bits must be ignored
    run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h12345655);
    check("sb_pulses", r_pulses, 32'd1);
    check("sb_wdata", r_wdata, 32'hDE55BEEF);
    check("sb_lat", r_lat, 32'd4);
    check("sb_mem", mem[4], 32'hDE55BEEF);

    // load extension on 0x80FF7F01
    run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF7F01);
    check("sw40_mem", mem[16], 32'h80FF7F01);

    ld_tab[0] = '{2'b00, 1'b0, 32'h43, 32'hFFFFFF80};
    ld_tab[1] = '{2'b00, 1'b1, 32'h43, 32'h00000080};
    ld_tab[2] = '{2'b01, 1'b0, 32'h40, 32'h00007F01};
    ld_tab[3] = '{2'b01, 1'b0, 32'h42, 32'hFFFF80FF};
    ld_tab[4] = '{2'b01, 1'b1, 32'h42, 32'h000080FF};
    ld_tab[5] = '{2'b00, 1'b0, 32'h41, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, ld_tab[i].size, ld_tab[i].uns, ld_tab[i].addr, 32'h0);
      check($sformatf("ld_ext%0d_rdata", i), r_rdata, ld_tab[i].exp);
      check($sformatf("ld_ext%0d_lat", i), r_lat, 32'd3);
    end

    // half store into the upper lane
    run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h9999ABCD);
    check("sh_wdata", r_wdata, 32'hABCD7F01);
    check("sh_lat", r_lat, 32'd4);
    check("sh_mem", mem[16], 32'hABCD7F01);

    // error cases: no RAM activity, 2-edge latency, zero data
    err_tab[0] = '{1'b0, 2'b01, 32'h11};
    err_tab[1] = '{1'b1, 2'b10, 32'h12};
    err_tab[2] = '{1'b0, 2'b11, 32'h10};
    err_tab[3] = '{1'b0, 2'b10, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      run_req(err_tab[i].we, err_tab[i].size, 1'b0, err_tab[i].addr, 32'h11223344);
      check($sformatf("err%0d_flag", i), {31'd0, r_err}, 32'd1);
      check($sformatf("err%0d_rdata", i), r_rdata, 32'h0);
      check($sformatf("err%0d_lat", i), r_lat, 32'd2);
      check($sformatf("err%0d_pulses", i), r_pulses, 32'd0);
      check($sformatf("err%0d_addr_moved", i), {31'd0, r_moved}, 32'd0);
    end
    check("err_mem_unchanged", mem[4], 32'hDE55BEEF);

    // last word of the RAM is legal
    run_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h13579BDF);
    check("top_sw_err", {31'd0, r_err}, 32'd0);
    check("top_sw_mem", mem[1023], 32'h13579BDF);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    check("top_lw_rdata", r_rdata, 32'h13579BDF);

    // handshake: second request held while the first is in flight
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h0;
    ready_low = 0; rsp_cnt = 0; a_err = 1'b1; b_seen = 1'b0; k = 0;
    while (!b_seen && k < 12) begin
      @(negedge clk);
      k++;
      if (rsp_valid) begin
        rsp_cnt++;
        a_err = rsp_err;
      end
      if (req_ready) b_seen = 1'b1;
      else ready_low++;
    end
    check("hs_ready_low_cycles", ready_low, 32'd2);
    check("hs_first_rsp_cnt", rsp_cnt, 32'd1);
    check("hs_first_err", {31'd0, a_err}, 32'd0);
    check("hs_second_seen", {31'd0, b_seen}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_cnt = 0; b_rdata = 32'h0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        b_rdata = rsp_rdata;
      end
    end
    check("hs_second_rsp_cnt", rsp_cnt, 32'd1);
    check("hs_second_rdata", b_rdata, 32'hCAFEF00D);
    check("hs_mem", mem[8], 32'hCAFEF00D);

    // reset during the WR cycle of a byte store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0; req_addr = 32'h11;
    req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rw_we_in_wr", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_we_dropped", {31'd0, ram_we}, 32'd0);
    check("rw_ram_addr", ram_addr, 32'h0);
    check("rw_ram_wdata", ram_wdata, 32'h0);
    check("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rw_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rw_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_ready_after", {31'd0, req_ready}, 32'd1);
    check("rw_mem_unchanged", mem[4], 32'hDE55BEEF);
    rsp_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("rw_no_rsp", rsp_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
